// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port 8-bit video RAM between scanout prefetch (pixel FIFO) and CPU req/ack accesses.
// Optional macro VRAM_CPU_ADDR_CHECK_EN: CPU addresses >= FB_SIZE ack with cpu_err=1 and never reach the RAM.
module vram_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FB_SIZE    = 480000,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_rd,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W:0] LOW_C   = (CNT_W+1)'(LOW_WATER);

  typedef enum logic [1:0] {CPU_IDLE, CPU_BUSY, CPU_WAIT, CPU_ACK} cpu_state_t;

  cpu_state_t        cpu_state, cpu_state_nxt;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic              tag_s1, tag_s2;
  logic              cpu_we_q, cpu_oor_q;
  logic              cpu_oor;
  logic              scan_elig, cpu_elig, scan_grant, cpu_grant, cpu_accept;
  logic              push, pop, fifo_empty;

`ifdef VRAM_CPU_ADDR_CHECK_EN
  logic cpu_err_r;
  assign cpu_oor = ({1'b0, cpu_addr} >= (ADDR_W+1)'(FB_SIZE));
  assign cpu_err = cpu_err_r;

  always_ff @(posedge clk) begin
    if (rst) cpu_err_r <= 1'b0;
    else     cpu_err_r <= (cpu_state == CPU_WAIT) && cpu_oor_q;
  end
`else
  assign cpu_oor = 1'b0;
  assign cpu_err = 1'b0;
`endif

  // Scan fetches still in the tag pipeline count as occupied so the FIFO can never overflow.
  assign occupancy  = {1'b0, count} + (CNT_W+1)'(tag_s1) + (CNT_W+1)'(tag_s2);
  assign fifo_empty = (count == '0);
  assign pix_valid  = !fifo_empty;
  assign pix_data   = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign push       = tag_s2 && !frame_start;
  assign pop        = pix_rd && !fifo_empty && !frame_start;

  always_comb begin
    scan_elig  = !frame_start && (occupancy < DEPTH_C);
    cpu_elig   = (cpu_state == CPU_IDLE) && cpu_req && !cpu_oor;
    scan_grant = scan_elig && (!cpu_elig || (occupancy < LOW_C));
    cpu_grant  = cpu_elig && !scan_grant;
    cpu_accept = cpu_grant || ((cpu_state == CPU_IDLE) && cpu_req && cpu_oor);
  end

  always_comb begin
    cpu_state_nxt = cpu_state;
    case (cpu_state)
      CPU_IDLE: if (cpu_accept) cpu_state_nxt = CPU_BUSY;
      CPU_BUSY: cpu_state_nxt = CPU_WAIT;
      CPU_WAIT: cpu_state_nxt = CPU_ACK;
      CPU_ACK:  cpu_state_nxt = CPU_IDLE;
      default:  cpu_state_nxt = CPU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_state <= CPU_IDLE;
      cpu_we_q  <= 1'b0;
      cpu_oor_q <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_state <= cpu_state_nxt;
      cpu_ack   <= (cpu_state == CPU_WAIT);
      if (cpu_accept) begin
        cpu_we_q  <= cpu_we;
        cpu_oor_q <= cpu_oor;
      end
      if ((cpu_state == CPU_WAIT) && !cpu_we_q && !cpu_oor_q) cpu_rdata <= mem_dout;
      else                                                     cpu_rdata <= '0;
    end
  end

  // A scan tag entering stage 2 while frame_start is high belongs to the old frame and is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      tag_s1   <= 1'b0;
      tag_s2   <= 1'b0;
    end else begin
      mem_en   <= scan_grant || cpu_grant;
      mem_we   <= cpu_grant && cpu_we;
      mem_addr <= scan_grant ? scan_addr : (cpu_grant ? cpu_addr : '0);
      mem_din  <= (cpu_grant && cpu_we) ? cpu_wdata : '0;
      tag_s1   <= scan_grant;
      tag_s2   <= tag_s1 && !frame_start;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || frame_start)
      scan_addr <= '0;
    else if (scan_grant)
      scan_addr <= (scan_addr == ADDR_W'(FB_SIZE-1)) ? '0 : scan_addr + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) underrun <= 1'b0;
    else if (pix_rd && fifo_empty && !frame_start) underrun <= 1'b1;
  end

  assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a 1-cycle block RAM model.
// Uses a 200-pixel framebuffer so scan-address wrap is reachable in a short run.
module tb_vram_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam int TB_FB  = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start;
  logic              pix_rd;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              underrun;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } cpu_exp_t;
  cpu_exp_t cpu_q[$];

  logic [7:0] ram     [0:(1<<ADDR_W)-1];
  logic [7:0] ref_mem [0:(1<<ADDR_W)-1];

  bit scan_watch = 1'b1;
  int prev_scan  = TB_FB - 1;
  int scan_count = 0;
  int wrap_count = 0;
  int exp_pix_addr = 0;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_SIZE(TB_FB), .FIFO_DEPTH(16), .LOW_WATER(4)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_rd(pix_rd),
    .pix_data(pix_data), .pix_valid(pix_valid), .underrun(underrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end
  end

  function automatic logic [7:0] pattern(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pixel scoreboard: each popped pixel must be the next frame address in the reference memory.
  always @(negedge clk) begin
    if (rst || frame_start) begin
      exp_pix_addr = 0;
    end else if (pix_rd && pix_valid) begin
      checkOutput("pix_data", 32'(pix_data), 32'(ref_mem[exp_pix_addr]));
      exp_pix_addr = (exp_pix_addr + 1) % TB_FB;
    end
  end

  always @(negedge clk) begin
    cpu_exp_t e;
    if (!rst && cpu_ack) begin
      if (cpu_q.size() == 0) begin
        checkOutput("cpu_ack_unexpected", 32'(cpu_ack), 32'd0);
      end else begin
        e = cpu_q.pop_front();
        checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
        checkOutput("cpu_err", 32'(cpu_err), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (rst || frame_start) begin
      prev_scan = TB_FB - 1;
    end else if (scan_watch && mem_en && !mem_we) begin
      checkOutput("scan_addr", 32'(mem_addr), 32'((prev_scan + 1) % TB_FB));
      if (prev_scan == TB_FB - 1 && scan_count > 0) wrap_count++;
      prev_scan = int'(mem_addr);
      scan_count++;
    end
  end

  // One CPU transaction; expectations are queued before the request is raised.
  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [7:0] wdata, input bit fifo_full);
    cpu_exp_t e;
    int lat;
    bit acked;
    bit oor;
    oor = 1'b0;
`ifdef VRAM_CPU_ADDR_CHECK_EN
    oor = (int'(addr) >= TB_FB);
`endif
    if (we && !oor) ref_mem[addr] = wdata;
    e.rdata = (we || oor) ? 8'h00 : ref_mem[addr];
    e.err   = oor;
    cpu_q.push_back(e);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    lat = 0;
    acked = 1'b0;
    while (!acked && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (fifo_full && lat == 1) begin
        checkOutput("issue_mem_en", 32'(mem_en), 32'(!oor));
        if (!oor) begin
          checkOutput("issue_mem_we", 32'(mem_we), 32'(we));
          checkOutput("issue_mem_addr", 32'(mem_addr), 32'(addr));
          checkOutput("issue_mem_din", 32'(mem_din), we ? 32'(wdata) : 32'd0);
        end
      end
      if (cpu_ack) begin
        acked = 1'b1;
        if (fifo_full) checkOutput("ack_latency", 32'(lat), 32'd3);
      end
    end
    if (!acked) checkOutput("cpu_ack_timeout", 32'd0, 32'd1);
    waitCycles(1);
    cpu_req = 1'b0;
  endtask

  task automatic startFrame(input bit rd_during);
    frame_start = 1'b1;
    pix_rd = rd_during;
    waitCycles(1);
    frame_start = 1'b0;
    pix_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      ram[a] = pattern(a);
      ref_mem[a] = pattern(a);
    end
    rst = 1'b1; frame_start = 1'b0; pix_rd = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    waitCycles(3);
    @(negedge clk);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst_pix_data", 32'(pix_data), 32'd0);
    checkOutput("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    checkOutput("rst_cpu_err", 32'(cpu_err), 32'd0);
    waitCycles(1);
    rst = 1'b0;

    // Idle fill: exactly 16 scan fetches, then the port goes quiet.
    waitCycles(25);
    @(negedge clk);
    checkOutput("fill_scan_count", 32'(scan_count), 32'd16);
    checkOutput("fill_mem_en", 32'(mem_en), 32'd0);
    checkOutput("fill_pix_valid", 32'(pix_valid), 32'd1);
    checkOutput("fill_pix_data", 32'(pix_data), 32'(pattern(0)));
    waitCycles(1);

    scan_watch = 1'b0;
    applyStimulus(1'b1, 19'd100, 8'hE3, 1'b1);
    applyStimulus(1'b1, 19'd150, 8'h11, 1'b1);
    applyStimulus(1'b0, 19'd100, 8'h00, 1'b1);
    applyStimulus(1'b0, 19'd5,   8'h00, 1'b1);

    // Display drains while the CPU keeps requesting.
    pix_rd = 1'b1;
    applyStimulus(1'b0, 19'd100, 8'h00, 1'b0);
    applyStimulus(1'b1, 19'd60,  8'hA5, 1'b0);
    applyStimulus(1'b0, 19'd150, 8'h00, 1'b0);
    applyStimulus(1'b0, 19'd20,  8'h00, 1'b0);
    applyStimulus(1'b0, 19'd60,  8'h00, 1'b0);
    waitCycles(20);
    @(negedge clk);
    checkOutput("stream_underrun", 32'(underrun), 32'd0);
    checkOutput("stream_cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    waitCycles(1);

    // frame_start while pixels stream and fetches are in flight.
    scan_watch = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    checkOutput("fs_fetch_in_flight", 32'(mem_en), 32'd1);
    waitCycles(1);
    frame_start = 1'b0;
    pix_rd = 1'b0;
    @(negedge clk);
    checkOutput("fs_fifo_empty", 32'(pix_valid), 32'd0);
    checkOutput("fs_no_grant", 32'(mem_en), 32'd0);
    waitCycles(25);
    @(negedge clk);
    checkOutput("fs_first_pixel", 32'(pix_data), 32'(pattern(0)));
    checkOutput("fs_pix_valid", 32'(pix_valid), 32'd1);
    checkOutput("fs_underrun", 32'(underrun), 32'd0);
    waitCycles(1);

    // Long stream across the framebuffer end exercises scan wrap.
    pix_rd = 1'b1;
    waitCycles(240);
    pix_rd = 1'b0;
    waitCycles(5);
    @(negedge clk);
    checkOutput("wrap_seen", 32'(wrap_count > 0), 32'd1);
    checkOutput("wrap_underrun", 32'(underrun), 32'd0);
    waitCycles(1);

    // Underrun is sticky across frame_start.
    startFrame(1'b0);
    pix_rd = 1'b1;
    waitCycles(1);
    pix_rd = 1'b0;
    @(negedge clk);
    checkOutput("underrun_set", 32'(underrun), 32'd1);
    waitCycles(1);
    startFrame(1'b0);
    waitCycles(25);
    @(negedge clk);
    checkOutput("underrun_sticky", 32'(underrun), 32'd1);
    checkOutput("refill_pixel", 32'(pix_data), 32'(pattern(0)));
    waitCycles(1);

    scan_watch = 1'b0;
    applyStimulus(1'b0, 19'(TB_FB), 8'h00, 1'b1);
    waitCycles(5);
    checkOutput("final_cpu_q_empty", 32'(cpu_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
